// File: rtl/movavg3_rr_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : movavg3_rr_sched_if
// Brief    : Per-channel sample inputs and tagged result stream of the
//            shared 3-tap moving-average scheduler.
// Revision : 1.0
// ============================================================================
interface movavg3_rr_sched_if #(
  parameter int NCH = 4,
  parameter int CW  = 2
);
  logic [NCH-1:0]   in_valid_i;
  logic [NCH*8-1:0] in_data_i;
  logic [NCH-1:0]   in_ready_o;
  logic             out_valid_o;
  logic [7:0]       out_data_o;
  logic [CW-1:0]    out_chan_o;
  logic             out_ready_i;

  modport master (
    output in_valid_i, in_data_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o, out_chan_o
  );

  modport slave (
    input  in_valid_i, in_data_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o, out_chan_o
  );
endinterface
`default_nettype wire

// File: rtl/movavg3_rr_sched.sv
`default_nettype none
// ============================================================================
// Module   : movavg3_rr_sched
// Brief    : Round-robin time-multiplexed 3-tap moving average over NCH
//            channels, with per-channel history and a tagged output register.
// Revision : 1.0
// ============================================================================
module movavg3_rr_sched #(
  parameter int NCH = 4,
  parameter int CW  = 2
) (
  input  logic                system1000,
  input  logic                system1000_rst,
  input  logic                clear_i,
  movavg3_rr_sched_if.slave   bus
);

  localparam logic [0:0]        c_empty   = 1'b0;
  localparam logic [0:0]        c_full    = 1'b1;
  localparam logic [CW-1:0]     c_ptr_rst = CW'(NCH - 1);
  localparam logic signed [9:0] c_three   = 10'sd3;

  logic [0:0]        r_state;
  logic [CW-1:0]     r_ptr;
  logic [7:0]        r_out_data;
  logic [CW-1:0]     r_out_chan;
  logic signed [7:0] r_h1 [NCH];
  logic signed [7:0] r_h2 [NCH];

  logic              w_can_accept;
  logic              w_found;
  logic [CW-1:0]     w_gidx;
  logic              w_xfer;
  logic [NCH-1:0]    w_ready;
  logic signed [7:0] w_x;
  logic signed [9:0] w_sum;
  logic signed [9:0] w_avg;

  assign w_can_accept = (r_state == c_empty) || bus.out_ready_i;

  // Priority search starts just past the last granted channel.
  always_comb begin : p_arb
    logic [CW-1:0] v_idx;
    v_idx   = '0;
    w_found = 1'b0;
    w_gidx  = '0;
    for (int i = 1; i <= NCH; i++) begin
      v_idx = CW'((int'(r_ptr) + i) % NCH);
      if (!w_found && bus.in_valid_i[v_idx]) begin
        w_found = 1'b1;
        w_gidx  = v_idx;
      end
    end
  end

  assign w_xfer  = w_found && w_can_accept && !clear_i && !system1000_rst;
  assign w_ready = w_xfer ? ({{(NCH-1){1'b0}}, 1'b1} << w_gidx) : '0;

  // Sign-extended 10-bit sum cannot overflow; signed division truncates toward zero.
  assign w_x   = bus.in_data_i[w_gidx*8 +: 8];
  assign w_sum = {{2{w_x[7]}}, w_x}
               + {{2{r_h1[w_gidx][7]}}, r_h1[w_gidx]}
               + {{2{r_h2[w_gidx][7]}}, r_h2[w_gidx]};
  assign w_avg = w_sum / c_three;

  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      r_state    <= c_empty;
      r_ptr      <= c_ptr_rst;
      r_out_data <= '0;
      r_out_chan <= '0;
      for (int k = 0; k < NCH; k++) begin
        r_h1[k] <= '0;
        r_h2[k] <= '0;
      end
    end else begin
      if (w_xfer) begin
        r_state    <= c_full;
        r_out_data <= w_avg[7:0];
        r_out_chan <= w_gidx;
        r_ptr      <= w_gidx;
      end else if (bus.out_ready_i) begin
        r_state    <= c_empty;
      end

      if (clear_i) begin
        for (int k = 0; k < NCH; k++) begin
          r_h1[k] <= '0;
          r_h2[k] <= '0;
        end
      end else if (w_xfer) begin
        r_h2[w_gidx] <= r_h1[w_gidx];
        r_h1[w_gidx] <= w_x;
      end
    end
  end

  assign bus.in_ready_o  = w_ready;
  assign bus.out_valid_o = (r_state == c_full);
  assign bus.out_data_o  = r_out_data;
  assign bus.out_chan_o  = r_out_chan;

endmodule
`default_nettype wire

// File: doc/movavg3_rr_sched.md
Name: movavg3_rr_sched

Overview:
- Time-multiplexes one 3-tap moving-average datapath across NCH independent sample channels.
- Each input channel has a valid/ready handshake. A round-robin arbiter grants one channel per cycle.
- Each channel keeps its own 2-sample history. Results leave through one valid/ready output stream tagged with the channel index.
- Sits between the per-channel sample sources and the downstream consumer. Replaces NCH separate moving-average instances.

Parameters:
- NCH, 4, number of requesting channels (2..8).
- CW, 2, channel-index width (= clog2(NCH)).

Ports:
- system1000  input  1  clock; all logic on rising edge.
- system1000_rst  input  1  reset, synchronous, active-high.
- clear_i  input  1  one-cycle pulse; zeroes all channel histories.
- in_valid_i  input  NCH  per-channel sample valid.
- in_data_i  input  NCH*8  per-channel signed 8-bit sample; channel k occupies bits [8k+7:8k].
- in_ready_o  output  NCH  per-channel accept; one-hot or zero.
- out_valid_o  output  1  result valid.
- out_data_o  output  8  signed 3-tap average.
- out_chan_o  output  CW  channel index of the result.
- out_ready_i  input  1  downstream accept.

Behaviour:
- Reset: one synchronous, active-high reset (system1000_rst) on the single clock system1000. While asserted, the block drives:
  - out_valid_o=0, out_data_o=0, out_chan_o=0, in_ready_o=0.
  - All histories h1[k]=h2[k]=0.
  - RR pointer=NCH-1, so channel 0 has first priority.
  - Reset mid-operation discards any held output without handshake.
- Output register state: EMPTY (out_valid_o=0) or FULL (out_valid_o=1).
  - can_accept = EMPTY, or (FULL and out_ready_i).
  - FULL with out_ready_i=0: out_data_o and out_chan_o stay stable.
- Arbitration (combinational, same cycle):
  - If can_accept=1 and clear_i=0, grant the first k with in_valid_i[k]=1, searching from pointer+1 upward modulo NCH.
  - in_ready_o is one-hot at the granted k; all zero when there is no grant.
  - Transfer on channel k when in_valid_i[k] and in_ready_o[k] are both 1.
  - Pointer is updated to k only on a transfer.
  - in_ready_o never depends on in_valid_i of non-granted channels, except through the priority search.
- Datapath on transfer of sample x on channel k (1-cycle latency):
  - sum = x + h1[k] + h2[k], as 10-bit signed with sign extension; no overflow possible.
  - avg = sum / 3, truncated toward zero; result always lies in [-128,127].
  - Next cycle: out_valid_o=1, out_data_o=avg, out_chan_o=k.
  - Histories update: h2[k]<=h1[k], h1[k]<=x. Other channels are untouched.
- Output handshake:
  - FULL with out_ready_i=1 and no new transfer: go to EMPTY.
  - FULL with out_ready_i=1 and a same-cycle transfer: reload. This gives back-to-back throughput of 1 result/cycle.
- clear_i:
  - Has priority over any transfer: no grant that cycle.
  - All histories are zeroed at the edge.
  - A held output result is unaffected and still drains normally.
- Boundaries:
  - No channel valid: no grant, pointer holds.
  - Single channel valid continuously: that channel is granted every cycle.
  - All channels valid: grants rotate 0,1,..,NCH-1,0.
  - Pointer wraps at NCH-1 to 0.
  - in_valid_i[k] dropped before transfer: no state change for k.

Test Plan:
- Reset, then ch0 sends 3,6,9 with out_ready_i=1 -> out_data_o 1,3,6; out_chan_o=0; out_valid_o rises 1 cycle after each transfer; results are back-to-back.
- All 4 channels valid with samples 30,60,90,120, out_ready_i=1 -> grant order 0,1,2,3,0; first-round outputs 10,20,30,40; in_ready_o one-hot each cycle.
- Ch1 sends -4, then -128,-128,-128 -> outputs -1 (trunc of -1.33), -44, -86, -128. Ch2 sends 127 x3 -> 42, 84, 127.
- out_ready_i=0 for 5 cycles with ch0 valid -> out_valid_o=1, data stable, in_ready_o=0. Release -> held result drains, then the next transfer produces the next result with no loss or duplication.
- Ch0 sends 90,90, then clear_i pulse coincident with ch0 valid -> no grant that cycle. Next sample 90 -> out_data_o=30 (history zeroed).
- Assert system1000_rst while out_valid_o=1 and histories nonzero -> next cycle out_valid_o=0, in_ready_o=0. After release, ch0 sample 9 -> 3 and channel 0 is granted first.
